// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: function codes and FSM states.
package alu_pkg;

  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;
  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
interface alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       alu_op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             zf;

  modport master (
    output start, alu_op, opA, opB,
    input  busy, done, result_lo, result_hi, zf
  );

  modport slave (
    input  start, alu_op, opA, opB,
    output busy, done, result_lo, result_hi, zf
  );
endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle function unit; unknown codes fall back to ADD.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [5:0]       alu_op,
  output logic [WIDTH-1:0] y
);
  localparam int SHW = $clog2(WIDTH);

  // Shift amount comes from the low bits of opA only.
  logic [SHW-1:0] shamt;
  assign shamt = opA[SHW-1:0];

  // Select the function result for the current code.
  always_comb begin
    y = opA + opB;
    case (alu_op)
      OP_ADD:  y = opA + opB;
      OP_SUB:  y = opA - opB;
      OP_AND:  y = opA & opB;
      OP_OR:   y = opA | opB;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
      OP_SLTU: y = {{(WIDTH-1){1'b0}}, (opA < opB)};
      OP_SLL:  y = opB << shamt;
      OP_SRL:  y = opB >> shamt;
      OP_SRA:  y = $unsigned($signed(opB) >>> shamt);
      default: y = opA + opB;
    endcase
  end
endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle ops via alu_core, MULTU by shift-add and
// DIVU by restoring division, one bit per clock, with registered results.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  nrst,
  alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic [WIDTH-1:0] work_hi;   // partial product high word / running remainder
  logic [WIDTH-1:0] work_lo;   // multiplier being consumed / quotient being built
  logic             done_reg;
  logic [WIDTH-1:0] result_lo_reg;
  logic [WIDTH-1:0] result_hi_reg;
  logic             zf_reg;
  logic [WIDTH-1:0] core_y;
  logic             is_last;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .opA    (bus.opA),
    .opB    (bus.opB),
    .alu_op (bus.alu_op),
    .y      (core_y)
  );

  assign is_last       = (count == SHW'(WIDTH - 1));
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_reg;
  assign bus.result_lo = result_lo_reg;
  assign bus.result_hi = result_hi_reg;
  assign bus.zf        = zf_reg;

  // One shift-add step: conditionally add the multiplicand, then shift the
  // {hi,lo} pair right so the consumed multiplier bit drops out.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
  always_comb begin
    mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opa_reg} : {(WIDTH+1){1'b0}});
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};
  end

  // One restoring-divide step: shift in the next dividend bit, trial subtract,
  // keep the difference only when it did not borrow.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;
  always_comb begin
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_reg};
    if (div_diff[WIDTH]) begin
      div_rem_next = div_shift[WIDTH-1:0];
      div_quo_next = {work_lo[WIDTH-2:0], 1'b0};
    end else begin
      div_rem_next = div_diff[WIDTH-1:0];
      div_quo_next = {work_lo[WIDTH-2:0], 1'b1};
    end
  end

  // FSM, iteration counter, operand latches and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      count         <= '0;
      opa_reg       <= '0;
      opb_reg       <= '0;
      work_hi       <= '0;
      work_lo       <= '0;
      done_reg      <= 1'b0;
      result_lo_reg <= '0;
      result_hi_reg <= '0;
      zf_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa_reg <= bus.opA;
            opb_reg <= bus.opB;
            count   <= '0;
            if (bus.alu_op == OP_MULTU) begin
              state   <= MUL;
              work_hi <= '0;
              work_lo <= bus.opB;
            end else if (bus.alu_op == OP_DIVU && bus.opB != '0) begin
              state   <= DIV;
              work_hi <= '0;
              work_lo <= bus.opA;
            end else if (bus.alu_op == OP_DIVU) begin
              // Divide by zero finishes immediately with a saturated quotient.
              result_lo_reg <= '1;
              result_hi_reg <= bus.opA;
              zf_reg        <= 1'b0;
              done_reg      <= 1'b1;
            end else begin
              result_lo_reg <= core_y;
              result_hi_reg <= '0;
              zf_reg        <= (core_y == '0);
              done_reg      <= 1'b1;
            end
          end
        end
        MUL: begin
          work_hi <= mul_hi_next;
          work_lo <= mul_lo_next;
          count   <= count + 1'b1;
          if (is_last) begin
            state         <= IDLE;
            count         <= '0;
            result_hi_reg <= mul_hi_next;
            result_lo_reg <= mul_lo_next;
            zf_reg        <= (mul_lo_next == '0);
            done_reg      <= 1'b1;
          end
        end
        DIV: begin
          work_hi <= div_rem_next;
          work_lo <= div_quo_next;
          count   <= count + 1'b1;
          if (is_last) begin
            state         <= IDLE;
            count         <= '0;
            result_hi_reg <= div_rem_next;
            result_lo_reg <= div_quo_next;
            zf_reg        <= (div_quo_next == '0);
            done_reg      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
